// File: rtl/bcd_scan_pkg.sv
// Shared constants for the multiplexed BCD display: segment patterns (active-low, g..a) and index width.
// latency: n/a (constants only); backpressure: none.
package bcd_scan_pkg;

  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_LAMP  = 7'h00;

  // Index 0 is the rightmost entry of the concatenation.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [3:0] anode_sel(input idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 decode to a dash.
// latency: 0 cycles; backpressure: none.
module bcd_seg_decode
  import bcd_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    if (bcd <= 4'd9) seg_n = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed BCD display driver with one-cycle anode dead time; BCD_SCAN_LZB_EN adds leading-zero blanking.
// latency: 1 CP from latch update to SEG_n on the selected digit; backpressure: none, scan is free-running.
module bcd_scan_display
  import bcd_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
)
(
  input  logic        CP,
  input  logic        CR_n,
  input  logic [15:0] BCD,
  input  logic        LE,
  input  logic        BI_n,
  input  logic        LT_n,
  output logic [6:0]  SEG_n,
  output logic [3:0]  AN_n
);

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] presc;
  logic        tick;
  idx_t        idx;
  logic [15:0] latch_q;
  logic [3:0]  nib;
  logic [6:0]  dec_seg;
  logic [3:0]  blank;

  assign tick = (presc == PRESC_LAST);
  assign nib  = latch_q[{idx, 2'b00} +: 4];

  bcd_seg_decode u_decode (
    .bcd   (nib),
    .seg_n (dec_seg)
  );

`ifdef BCD_SCAN_LZB_EN
  // A digit blanks only if it is zero and everything to its left is blanked.
  always_comb begin
    blank    = '0;
    blank[3] = (latch_q[15:12] == 4'd0);
    blank[2] = (latch_q[11:8]  == 4'd0) && blank[3];
    blank[1] = (latch_q[7:4]   == 4'd0) && blank[2];
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      presc   <= '0;
      idx     <= '0;
      latch_q <= '0;
    end else begin
      if (LE) latch_q <= BCD;
      presc <= tick ? '0 : presc + 16'd1;
      if (tick) idx <= idx + 2'd1;
    end
  end

  // SEG_n is taken from the index before a tick, so the new digit's pattern
  // lands together with its anode once the dead-time cycle has passed.
  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      AN_n  <= 4'hF;
      SEG_n <= SEG_BLANK;
    end else begin
      if (!BI_n || tick) AN_n <= 4'hF;
      else               AN_n <= anode_sel(idx);

      if (!BI_n)           SEG_n <= SEG_BLANK;
      else if (!LT_n)      SEG_n <= SEG_LAMP;
      else if (blank[idx]) SEG_n <= SEG_BLANK;
      else                 SEG_n <= dec_seg;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display at SCAN_DIV=4; expectations follow BCD_SCAN_LZB_EN when defined.
module tb_bcd_scan_display;

  logic        CP;
  logic        CR_n;
  logic [15:0] BCD;
  logic        LE;
  logic        BI_n;
  logic        LT_n;
  logic [6:0]  SEG_n;
  logic [3:0]  AN_n;

  int vectors;
  int miscompares;

`ifdef BCD_SCAN_LZB_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [3:0] AN_TAB  [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
  localparam logic [6:0] SEG_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

  bcd_scan_display #(.SCAN_DIV(4)) dut (
    .CP    (CP),
    .CR_n  (CR_n),
    .BCD   (BCD),
    .LE    (LE),
    .BI_n  (BI_n),
    .LT_n  (LT_n),
    .SEG_n (SEG_n),
    .AN_n  (AN_n)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic step(input int n);
    repeat (n) @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    CR_n = 1'b1;
    BCD  = 16'h0000;
    LE   = 1'b0;
    BI_n = 1'b1;
    LT_n = 1'b1;

    // Reset: outputs forced immediately and held while the clock runs.
    #1 CR_n = 1'b0;
    #1;
    chk("rst_an",  {3'b0, AN_n}, 7'hF);
    chk("rst_seg", SEG_n, 7'h7F);
    step(2);
    chk("rst_hold_an",  {3'b0, AN_n}, 7'hF);
    chk("rst_hold_seg", SEG_n, 7'h7F);

    // Release with 1234 latched on the first edge.
    BCD  = 16'h1234;
    LE   = 1'b1;
    CR_n = 1'b1;
    step(1);
    LE = 1'b0;
    chk("e1_an",  {3'b0, AN_n}, 7'hE);
    chk("e1_seg", SEG_n, 7'h40);
    step(1);
    chk("e2_an",  {3'b0, AN_n}, 7'hE);
    chk("e2_seg", SEG_n, 7'h19);
    step(1);
    for (int s = 1; s < 4; s++) begin
      step(1);
      chk("scan_dead", {3'b0, AN_n}, 7'hF);
      step(1);
      chk("scan_an",  {3'b0, AN_n}, {3'b0, AN_TAB[s]});
      chk("scan_seg", SEG_n, SEG_1234[s]);
      step(2);
    end
    step(1);
    chk("wrap_dead", {3'b0, AN_n}, 7'hF);
    step(1);
    chk("wrap_an",  {3'b0, AN_n}, 7'hE);
    chk("wrap_seg", SEG_n, 7'h19);

    // Latch 0057 while digit 0 is selected: one cycle to reach SEG_n.
    BCD = 16'h0057;
    LE  = 1'b1;
    step(1);
    LE = 1'b0;
    chk("lat_old_seg", SEG_n, 7'h19);
    step(1);
    chk("lat_new_seg", SEG_n, 7'h78);
    chk("lat_new_an",  {3'b0, AN_n}, 7'hE);
    step(1);
    chk("z57_dead", {3'b0, AN_n}, 7'hF);
    step(1);
    chk("z57_d1_an",  {3'b0, AN_n}, 7'hD);
    chk("z57_d1_seg", SEG_n, 7'h12);
    step(4);
    chk("z57_d2_an",  {3'b0, AN_n}, 7'hB);
    chk("z57_d2_seg", SEG_n, LZ_SEG);
    step(4);
    chk("z57_d3_an",  {3'b0, AN_n}, 7'h7);
    chk("z57_d3_seg", SEG_n, LZ_SEG);
    step(4);
    chk("z57_d0_an",  {3'b0, AN_n}, 7'hE);
    chk("z57_d0_seg", SEG_n, 7'h78);

    // A000 latched on the tick edge itself; the dead cycle still shows old data.
    step(2);
    BCD = 16'hA000;
    LE  = 1'b1;
    step(1);
    LE = 1'b0;
    chk("a0_tick_an",  {3'b0, AN_n}, 7'hF);
    chk("a0_tick_seg", SEG_n, 7'h78);
    step(1);
    chk("a0_d1_an",  {3'b0, AN_n}, 7'hD);
    chk("a0_d1_seg", SEG_n, 7'h40);
    step(4);
    chk("a0_d2_an",  {3'b0, AN_n}, 7'hB);
    chk("a0_d2_seg", SEG_n, 7'h40);
    step(4);
    chk("a0_d3_an",  {3'b0, AN_n}, 7'h7);
    chk("a0_d3_seg", SEG_n, 7'h3F);
    step(4);
    chk("a0_d0_an",  {3'b0, AN_n}, 7'hE);
    chk("a0_d0_seg", SEG_n, 7'h40);

    // Blanking beats lamp test; scanning continues underneath.
    BI_n = 1'b0;
    LT_n = 1'b0;
    step(1);
    chk("bi_an",  {3'b0, AN_n}, 7'hF);
    chk("bi_seg", SEG_n, 7'h7F);
    step(1);
    chk("bi_hold_seg", SEG_n, 7'h7F);
    BI_n = 1'b1;
    step(1);
    chk("lt_tick_an",  {3'b0, AN_n}, 7'hF);
    chk("lt_tick_seg", SEG_n, 7'h00);
    step(1);
    chk("lt_an",  {3'b0, AN_n}, 7'hD);
    chk("lt_seg", SEG_n, 7'h00);
    LT_n = 1'b1;
    step(1);
    chk("lt_off_an",  {3'b0, AN_n}, 7'hD);
    chk("lt_off_seg", SEG_n, 7'h40);

    // Reset mid-slot with digit 2 selected.
    step(3);
    chk("pre_rst_an", {3'b0, AN_n}, 7'hB);
    #2 CR_n = 1'b0;
    #1;
    chk("mid_rst_an",  {3'b0, AN_n}, 7'hF);
    chk("mid_rst_seg", SEG_n, 7'h7F);
    #2 CR_n = 1'b1;
    step(1);
    chk("rst_r1_an",  {3'b0, AN_n}, 7'hE);
    chk("rst_r1_seg", SEG_n, 7'h40);
    step(4);
    chk("rst_r5_an",  {3'b0, AN_n}, 7'hD);
    chk("rst_r5_seg", SEG_n, LZ_SEG);
    step(8);
    chk("rst_r13_an",  {3'b0, AN_n}, 7'h7);
    chk("rst_r13_seg", SEG_n, LZ_SEG);

    // LE held high with BCD changing every cycle: display trails by one capture.
    LE = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      BCD = 16'(i * 16'h1111);
      step(1);
      if (i > 1) chk("stream_seg", SEG_n, SEG_TAB[i-1]);
    end
    LE = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
